// File: rtl/int2float_pkg.sv
// Shared constants and parameter helpers for the integer-to-minifloat converter.
package int2float_pkg;

  // Rounding mode encoding carried alongside each word
  localparam logic TRUNC = 1'b0;
  localparam logic RNE   = 1'b1;

  // Packed result width: sign, exponent, stored mantissa
  function automatic int calc_out_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  // Largest encodable exponent value
  function automatic int calc_exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // Every normalised input must fit the exponent field before rounding
  function automatic bit exp_w_legal(input int in_w, input int exp_w, input int man_w);
    return (in_w > man_w) && ((in_w - man_w) <= calc_exp_max(exp_w));
  endfunction

endpackage

// File: rtl/int2float_lod.sv
// Combinational leading-one detector: position of the highest set bit.
module int2float_lod
  import int2float_pkg::*;
#(
  parameter int W  = 11,
  parameter int PW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  i_vec,
  output logic [PW-1:0] o_pos,
  output logic          o_zero
);

  // Scan upward so the last hit is the most significant one
  always_comb begin
    o_pos  = '0;
    o_zero = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (i_vec[i]) begin
        o_pos  = PW'(i);
        o_zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/int2float_pipe.sv
// Three-stage valid/ready integer-to-minifloat converter with rounding,
// saturation, inexact flag and a saturation event counter.
module int2float_pipe
  import int2float_pkg::*;
#(
  parameter int IN_W  = 11,
  parameter int EXP_W = 3,
  parameter int MAN_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_data,
  input  logic                   in_signed,
  input  logic                   in_rne,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data,
  output logic                   out_inexact,
  output logic                   out_sat,
  output logic [CNT_W-1:0]       sat_count,
  input  logic                   sat_clr
);

  localparam int OUT_W   = calc_out_w(EXP_W, MAN_W);
  localparam int EXP_MAX = calc_exp_max(EXP_W);
  localparam int PW      = (IN_W > 1) ? $clog2(IN_W) : 1;

  if (!exp_w_legal(IN_W, EXP_W, MAN_W)) begin : g_bad_params
    $fatal(1, "int2float_pipe: IN_W-MAN_W must be in 1..2^EXP_W-1");
  end

  logic               w_s1_en, w_s2_en, w_s3_en;
  logic               w_s1_sign;
  logic [IN_W-1:0]    w_s1_mag;

  logic               r_s1_valid, r_s1_sign, r_s1_rne;
  logic [IN_W-1:0]    r_s1_mag;

  logic [PW-1:0]      w_lod_pos;
  logic               w_lod_zero;
  logic               w_small;
  logic [PW:0]        w_shamt;
  logic [IN_W:0]      w_frac;
  logic [EXP_W-1:0]   w_s2_exp;
  logic [MAN_W-1:0]   w_s2_man;
  logic               w_s2_guard, w_s2_sticky;

  logic               r_s2_valid, r_s2_sign, r_s2_rne, r_s2_guard, r_s2_sticky;
  logic [EXP_W-1:0]   r_s2_exp;
  logic [MAN_W-1:0]   r_s2_man;

  logic               w_up;
  logic [MAN_W:0]     w_man_sum;
  logic [EXP_W:0]     w_exp_sum;
  logic [EXP_W-1:0]   w_s3_exp;
  logic [MAN_W-1:0]   w_s3_man;
  logic               w_s3_sat;

  logic               r_out_valid, r_out_inexact, r_out_sat;
  logic [OUT_W-1:0]   r_out_data;
  logic [CNT_W-1:0]   r_sat_count;

  // A stage loads when its slot is empty or its content moves on this edge
  assign w_s3_en  = ~r_out_valid | out_ready;
  assign w_s2_en  = ~r_s2_valid | w_s3_en;
  assign w_s1_en  = ~r_s1_valid | w_s2_en;
  assign in_ready = w_s1_en;

  assign w_s1_sign = in_signed & in_data[IN_W-1];
  assign w_s1_mag  = w_s1_sign ? -in_data : in_data;

  // Stage 1 register: sign and magnitude of the accepted word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_rne   <= 1'b0;
      r_s1_mag   <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign <= w_s1_sign;
        r_s1_rne  <= in_rne;
        r_s1_mag  <= w_s1_mag;
      end
    end
  end

  int2float_lod #(.W(IN_W), .PW(PW)) u_lod (
    .i_vec  (r_s1_mag),
    .o_pos  (w_lod_pos),
    .o_zero (w_lod_zero)
  );

  // Normalise: shift the leading one out so the fraction bits sit at the top
  always_comb begin
    w_small     = w_lod_zero || (w_lod_pos < PW'(MAN_W));
    w_shamt     = (PW+1)'(IN_W) - {1'b0, w_lod_pos};
    w_frac      = {r_s1_mag, 1'b0} << w_shamt;
    w_s2_exp    = '0;
    w_s2_man    = r_s1_mag[MAN_W-1:0];
    w_s2_guard  = 1'b0;
    w_s2_sticky = 1'b0;
    if (!w_small) begin
      w_s2_exp    = EXP_W'(32'(w_lod_pos) - (MAN_W - 1));
      w_s2_man    = w_frac[IN_W -: MAN_W];
      w_s2_guard  = w_frac[IN_W-MAN_W];
      w_s2_sticky = |w_frac[IN_W-MAN_W-1:0];
    end
  end

  // Stage 2 register: exponent, mantissa and the bits needed for rounding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_sign   <= 1'b0;
      r_s2_rne    <= 1'b0;
      r_s2_exp    <= '0;
      r_s2_man    <= '0;
      r_s2_guard  <= 1'b0;
      r_s2_sticky <= 1'b0;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sign   <= r_s1_sign;
        r_s2_rne    <= r_s1_rne;
        r_s2_exp    <= w_s2_exp;
        r_s2_man    <= w_s2_man;
        r_s2_guard  <= w_s2_guard;
        r_s2_sticky <= w_s2_sticky;
      end
    end
  end

  // Round, propagate mantissa carry into the exponent, clamp on overflow
  always_comb begin
    w_up = 1'b0;
    case (r_s2_rne)
      TRUNC:   w_up = 1'b0;
      RNE:     w_up = r_s2_guard & (r_s2_sticky | r_s2_man[0]);
      default: w_up = 1'b0;
    endcase
    w_man_sum = {1'b0, r_s2_man} + (MAN_W+1)'(w_up);
    w_exp_sum = {1'b0, r_s2_exp} + (EXP_W+1)'(w_man_sum[MAN_W]);
    w_s3_sat  = 1'b0;
    w_s3_exp  = w_exp_sum[EXP_W-1:0];
    w_s3_man  = w_man_sum[MAN_W-1:0];
    if (w_exp_sum > (EXP_W+1)'(EXP_MAX)) begin
      w_s3_sat = 1'b1;
      w_s3_exp = '1;
      w_s3_man = '1;
    end
  end

  // Output register: holds the packed result until downstream takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_inexact <= 1'b0;
      r_out_sat     <= 1'b0;
    end else if (w_s3_en) begin
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_data    <= {r_s2_sign, w_s3_exp, w_s3_man};
        r_out_inexact <= r_s2_guard | r_s2_sticky;
        r_out_sat     <= w_s3_sat;
      end
    end
  end

  // Saturating count of clamped results taken downstream; clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat_count <= '0;
    end else if (sat_clr) begin
      r_sat_count <= '0;
    end else if (r_out_valid && out_ready && r_out_sat && !(&r_sat_count)) begin
      r_sat_count <= r_sat_count + 1'b1;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_inexact = r_out_inexact;
  assign out_sat     = r_out_sat;
  assign sat_count   = r_sat_count;

endmodule

// File: tb/tb_int2float_pipe.sv
// Directed self-checking bench for int2float_pipe with default parameters.
module tb_int2float_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_signed, in_rne;
  logic [10:0] in_data;
  logic        out_valid, out_ready, out_inexact, out_sat, sat_clr;
  logic [7:0]  out_data;
  logic [15:0] sat_count;

  int checks   = 0;
  int failures = 0;

  int2float_pipe #(.IN_W(11), .EXP_W(3), .MAN_W(4), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_signed   (in_signed),
    .in_rne      (in_rne),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_inexact (out_inexact),
    .out_sat     (out_sat),
    .sat_count   (sat_count),
    .sat_clr     (sat_clr)
  );

  // Free-running 10-unit clock
  initial forever #5 clk = ~clk;

  // Send one word into an idle pipe and report the first result seen and its latency
  task automatic run_one(input logic [10:0] d, input logic sg, input logic rn,
                         output logic [7:0] od, output logic oi, output logic os,
                         output int lat);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    in_signed = sg;
    in_rne    = rn;
    lat = -1;
    od = '0; oi = 1'b0; os = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        lat = n;
        od = out_data; oi = out_inexact; os = out_sat;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_signed = 1'b0;
    in_rne = 1'b0; out_ready = 1'b0; sat_clr = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_inexact, out_sat, sat_count} !== 27'd0) begin
      failures++;
      $display("[TB] FAIL reset_state: got valid=%b data=%h inx=%b sat=%b cnt=%0d, expected all zero",
               out_valid, out_data, out_inexact, out_sat, sat_count);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] vin  [5] = '{11'd0, 11'd13, 11'd16, 11'd25, 11'd100};
    logic [7:0]  vexp [5] = '{8'h00, 8'h0D, 8'h10, 8'h19, 8'h39};
    out_ready = 1'b1; in_signed = 1'b0; in_rne = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 3) begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL b2b_early_valid c=%0d: got %b expected 0", c, out_valid);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== vexp[c-3] || out_inexact !== 1'b0) begin
          failures++;
          $display("[TB] FAIL b2b_word%0d: got v=%b data=%h inx=%b expected v=1 data=%h inx=0",
                   c-3, out_valid, out_data, out_inexact, vexp[c-3]);
        end
      end
      if (c < 5) begin
        in_valid = 1'b1;
        in_data  = vin[c];
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_rounding();
    logic [7:0] od; logic oi, os; int lat;
    out_ready = 1'b1;
    run_one(11'd35, 1'b0, 1'b0, od, oi, os, lat);
    checks++;
    if (lat !== 3 || od !== 8'h21 || oi !== 1'b1 || os !== 1'b0) begin
      failures++;
      $display("[TB] FAIL trunc_35: got lat=%0d data=%h inx=%b sat=%b expected lat=3 data=21 inx=1 sat=0", lat, od, oi, os);
    end
    run_one(11'd35, 1'b0, 1'b1, od, oi, os, lat);
    checks++;
    if (lat !== 3 || od !== 8'h22 || oi !== 1'b1 || os !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rne_35: got lat=%0d data=%h inx=%b sat=%b expected lat=3 data=22 inx=1 sat=0", lat, od, oi, os);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] od; logic oi, os; int lat;
    out_ready = 1'b1;
    run_one(11'd2047, 1'b0, 1'b0, od, oi, os, lat);
    checks++;
    if (lat !== 3 || od !== 8'h7F || oi !== 1'b1 || os !== 1'b0) begin
      failures++;
      $display("[TB] FAIL trunc_2047: got lat=%0d data=%h inx=%b sat=%b expected lat=3 data=7f inx=1 sat=0", lat, od, oi, os);
    end
    @(negedge clk);
    checks++;
    if (sat_count !== 16'd0) begin
      failures++;
      $display("[TB] FAIL sat_count_after_trunc: got %0d expected 0", sat_count);
    end
    run_one(11'd2047, 1'b0, 1'b1, od, oi, os, lat);
    checks++;
    if (lat !== 3 || od !== 8'h7F || oi !== 1'b1 || os !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rne_2047: got lat=%0d data=%h inx=%b sat=%b expected lat=3 data=7f inx=1 sat=1", lat, od, oi, os);
    end
    @(negedge clk);
    checks++;
    if (sat_count !== 16'd1) begin
      failures++;
      $display("[TB] FAIL sat_count_inc: got %0d expected 1", sat_count);
    end
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    checks++;
    if (sat_count !== 16'd0) begin
      failures++;
      $display("[TB] FAIL sat_count_clr: got %0d expected 0", sat_count);
    end
  endtask

  task automatic test_signed();
    logic [7:0] od; logic oi, os; int lat;
    out_ready = 1'b1;
    run_one(11'h79C, 1'b1, 1'b0, od, oi, os, lat);
    checks++;
    if (lat !== 3 || od !== 8'hB9 || oi !== 1'b0 || os !== 1'b0) begin
      failures++;
      $display("[TB] FAIL signed_m100: got lat=%0d data=%h inx=%b sat=%b expected lat=3 data=b9 inx=0 sat=0", lat, od, oi, os);
    end
    run_one(11'h400, 1'b1, 1'b1, od, oi, os, lat);
    checks++;
    if (lat !== 3 || od !== 8'hF0 || oi !== 1'b0 || os !== 1'b0) begin
      failures++;
      $display("[TB] FAIL signed_m1024: got lat=%0d data=%h inx=%b sat=%b expected lat=3 data=f0 inx=0 sat=0", lat, od, oi, os);
    end
    run_one(11'h400, 1'b0, 1'b0, od, oi, os, lat);
    checks++;
    if (lat !== 3 || od !== 8'h70 || oi !== 1'b0 || os !== 1'b0) begin
      failures++;
      $display("[TB] FAIL unsigned_1024: got lat=%0d data=%h inx=%b sat=%b expected lat=3 data=70 inx=0 sat=0", lat, od, oi, os);
    end
  endtask

  task automatic test_back_pressure();
    logic [10:0] w    [8] = '{11'd16, 11'd25, 11'd100, 11'd13, 11'd1, 11'd2, 11'd3, 11'd4};
    logic [7:0]  wexp [8] = '{8'h10, 8'h19, 8'h39, 8'h0D, 8'h01, 8'h02, 8'h03, 8'h04};
    int sent = 0, got = 0, occ = 0, cyc = 0;
    logic held_v = 1'b0;
    logic [7:0] held_d = '0;
    in_signed = 1'b0; in_rne = 1'b0;
    while (got < 8 && cyc < 40) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      if (sent < 8) begin
        in_valid = 1'b1;
        in_data  = w[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (held_v) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_d) begin
          failures++;
          $display("[TB] FAIL stall_hold cyc=%0d: got v=%b data=%h expected v=1 data=%h", cyc, out_valid, out_data, held_d);
        end
      end
      checks++;
      if (in_ready !== !(occ == 3 && !out_ready)) begin
        failures++;
        $display("[TB] FAIL stall_in_ready cyc=%0d: got %b expected %b", cyc, in_ready, !(occ == 3 && !out_ready));
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (out_data !== wexp[got]) begin
          failures++;
          $display("[TB] FAIL stall_order idx=%0d: got %h expected %h", got, out_data, wexp[got]);
        end
        got++;
        occ--;
      end
      held_v = (out_valid === 1'b1) && !out_ready;
      held_d = out_data;
      if (in_valid && in_ready === 1'b1) begin
        sent++;
        occ++;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sent !== 8 || got !== 8 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_count: got sent=%0d recv=%0d trailing_valid=%b expected 8 8 0", sent, got, out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] od; logic oi, os; int lat;
    out_ready = 1'b1; in_signed = 1'b0; in_rne = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 11'(20 + k);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_inflight: got out_valid=%b expected 1", out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_clear: got v=%b data=%h rdy=%b expected v=0 data=00 rdy=1", out_valid, out_data, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    run_one(11'd100, 1'b0, 1'b0, od, oi, os, lat);
    checks++;
    if (lat !== 3 || od !== 8'h39) begin
      failures++;
      $display("[TB] FAIL midreset_first_word: got lat=%0d data=%h expected lat=3 data=39", lat, od);
    end
  endtask

  // Scenario sequence followed by the single summary line
  initial begin
    test_reset();
    test_back_to_back();
    test_rounding();
    test_saturation();
    test_signed();
    test_back_pressure();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int2float_pipe.md
Name: int2float_pipe

Overview:
- Parametrised, pipelined successor to the 11-bit-to-7-bit integer-to-float converter.
- Converts an IN_W-bit integer, unsigned or two's-complement, into a packed {sign, exponent, mantissa} minifloat.
- Supports runtime-selectable truncate or round-to-nearest-even, with saturation and inexact flags.
- Sits on a valid/ready stream between the sample front-end and the float datapath; one conversion per cycle.

Parameters:
- IN_W, 11: input integer width.
- EXP_W, 3: exponent width. Must satisfy IN_W-MAN_W <= 2^EXP_W-1; elaboration fails otherwise.
- MAN_W, 4: stored mantissa width (hidden one not stored).
- CNT_W, 16: width of the saturation event counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word this cycle
- in_data  in  IN_W  integer operand
- in_signed  in  1  1: in_data is two's complement; 0: unsigned
- in_rne  in  1  1: round-nearest-even; 0: truncate
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  1+EXP_W+MAN_W  {sign, exp, man}
- out_inexact  out  1  discarded bits were non-zero
- out_sat  out  1  rounding overflowed the exponent; result clamped
- sat_count  out  CNT_W  saturating count of out_sat results accepted downstream
- sat_clr  in  1  synchronous clear of sat_count

Behaviour:
- Reset: all stage valids, out_valid, out_data, flags and sat_count go to 0. in_ready is 1 once reset is released. Reset mid-stream discards every in-flight word.
- Handshake: a word transfers when valid & ready on the same edge.
  - in_data, in_signed and in_rne are sampled together at transfer.
  - out_* are held stable while out_valid & ~out_ready.
- Pipeline: 3 register stages; latency is exactly 3 cycles with no stall; throughput 1/cycle.
  - Each stage advances when its output slot is empty or downstream is consuming (bubble collapsing).
  - in_ready = ~s1_valid | s1 advancing. Combinational path from out_ready to in_ready is permitted.
- S1, sign/magnitude:
  - sign = in_signed & in_data[IN_W-1], otherwise 0.
  - mag = sign ? -in_data : in_data, IN_W bits unsigned. The most negative input gives mag = 2^(IN_W-1).
- S2, normalise: a leading-one detector gives msb position p.
  - mag < 2^MAN_W: exp=0, man=mag[MAN_W-1:0], exact (denormal/zero).
  - Otherwise: exp = p-MAN_W+1, man = mag[p-1:p-MAN_W].
  - guard = mag[p-MAN_W-1], or 0 if that bit does not exist.
  - sticky = OR of the bits below guard.
- S3, round/pack:
  - inexact = guard|sticky.
  - RNE rounds up when guard & (sticky | man[0]); truncate never rounds up.
  - Mantissa carry-out: man=0, exp+1.
  - If exp would exceed 2^EXP_W-1: exp=all ones, man=all ones, out_sat=1.
  - out_data = {sign, exp, man}.
- Zero input gives out_data=0 with both flags 0; negative zero is never produced.
- sat_count increments on each accepted result (out_valid & out_ready) with out_sat=1 and sticks at all-ones.
  - sat_clr has priority over an increment in the same cycle.

Decomposition:
- Package int2float_pkg:
  - round-mode encoding constants (TRUNC=0, RNE=1);
  - derived width constants (OUT_W=1+EXP_W+MAN_W, EXP_MAX);
  - a function checking the EXP_W legality condition.
- Sub-module int2float_lod: parametrised combinational leading-one detector returning p and a zero flag, instantiated in S2.
- Everything else lives in int2float_pipe.

Test Plan:
1. Unsigned, truncate, back-to-back 0,13,16,25,100 with out_ready=1 -> out_data 0x00,0x0D,0x10,0x19,0x39 on cycles 3..7; inexact=0 for all.
2. Unsigned 35, then 35 again: truncate -> 0x21, inexact=1; RNE -> 0x22, inexact=1.
3. Unsigned 2047: truncate -> 0x7F, sat=0, inexact=1; RNE -> 0x7F, sat=1, inexact=1; sat_count=1, then 0 after sat_clr.
4. Signed -100 (0x79C) -> 0xB9. Signed -1024 (0x400) -> 0xF0, exact.
5. Stream 8 words while holding out_ready=0 for 5 cycles -> out_data held stable, in_ready=0 once three words are buffered, no loss or duplication, order preserved.
6. Assert rst while 3 words are in flight -> all valids 0 immediately; first post-reset word emerges after exactly 3 cycles.
